// File: rtl/cpu_branch_pkg.sv
// ----------------------------------------------------------------------------
// cpu_branch_pkg
// Shared encodings for the execute-stage branch path: branch opcodes, compare
// flag values and flag bit positions, plus the branch unit's FSM state type.
// ----------------------------------------------------------------------------
package cpu_branch_pkg;

    typedef enum logic [2:0] {
        BR_B    = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BGT  = 3'd2,
        BR_BLT  = 3'd3,
        BR_CALL = 3'd4,
        BR_RET  = 3'd5
    } br_op_e;

    // Compare flags are {gt,eq}
    localparam logic [1:0] FLAG_LT = 2'b00;
    localparam logic [1:0] FLAG_EQ = 2'b01;
    localparam logic [1:0] FLAG_GT = 2'b10;

    localparam int FLAG_EQ_BIT = 0;
    localparam int FLAG_GT_BIT = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_e;

endpackage

// File: rtl/branch_ras.sv
// ----------------------------------------------------------------------------
// branch_ras
// Return-address stack built as a circular buffer. A push onto a full stack
// overwrites the oldest entry and the occupancy saturates at RAS_DEPTH.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write a new return address on top
//   pop               discard the top entry (ignored when empty)
//   pop_data          current top entry (combinational, undefined when empty)
//   empty, full       occupancy status
// ----------------------------------------------------------------------------
module branch_ras #(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_top_ptr;   // next slot to write
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_ptr;

    assign w_rd_ptr = r_top_ptr - PTR_W'(1);
    assign pop_data = r_mem[w_rd_ptr];
    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_W'(RAS_DEPTH));

    // When full, r_top_ptr already points at the oldest entry, so a plain
    // write there implements overwrite-oldest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top_ptr <= '0;
            r_count   <= '0;
        end else if (push) begin
            r_top_ptr <= r_top_ptr + PTR_W'(1);
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_top_ptr <= w_rd_ptr;
            r_count   <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_top_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Holds the architectural compare flags and resolves conditional branches,
// calls and returns against them. A taken branch produces a one-cycle
// registered redirect and holds flush for FLUSH_CYCLES cycles, during which
// no new branch is accepted.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   flags_wr_en, flags_wr_data    flag write from the ALU compare ({gt,eq})
//   br_valid, br_ready            branch issue handshake
//   br_op, br_pc, br_offset       branch opcode, its PC, two's-complement offset
//   redirect_valid, redirect_pc   one-cycle fetch redirect
//   flush                         kill younger instructions
//   flags_q                       current flags register
//   ras_empty, ras_full, ras_err  return stack status, RET-on-empty pulse
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import cpu_branch_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flags_wr_en,
    input  logic [1:0]      flags_wr_data,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_offset,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic [1:0]      flags_q,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    localparam int CNT_W = 4;

    bru_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_flags;
    logic             r_redirect_valid;
    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_ras_err;

    logic [1:0]       w_flags_eff;
    logic             w_accept;
    logic             w_taken;
    logic             w_ret_err;
    logic             w_push;
    logic             w_pop;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_ret_addr;
    logic [PC_W-1:0]  w_ras_top;
    logic             w_ras_empty;
    logic             w_ras_full;

    // Same-cycle flag write is forwarded to the condition check
    assign w_flags_eff = flags_wr_en ? flags_wr_data : r_flags;
    assign w_accept    = br_valid && br_ready;
    assign w_ret_addr  = br_pc + PC_W'(1);

    always_comb begin
        w_taken   = 1'b0;
        w_ret_err = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_target  = br_pc + br_offset;   // wraps modulo 2^PC_W
        if (w_accept) begin
            case (br_op)
                BR_B:    w_taken = 1'b1;
                BR_BEQ:  w_taken = (w_flags_eff == FLAG_EQ);
                BR_BGT:  w_taken = (w_flags_eff == FLAG_GT);
                BR_BLT:  w_taken = (w_flags_eff == FLAG_LT);
                BR_CALL: begin
                    w_taken = 1'b1;
                    w_push  = 1'b1;
                end
                BR_RET: begin
                    w_taken = 1'b1;
                    if (w_ras_empty) begin
                        w_target  = '0;
                        w_ret_err = 1'b1;
                    end else begin
                        w_target  = w_ras_top;
                        w_pop     = 1'b1;
                    end
                end
                default: w_taken = 1'b0;
            endcase
        end
    end

    branch_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_ret_addr),
        .pop_data  (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    // Flush FSM: counter holds the flush cycles remaining including this one
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_taken) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_flags          <= FLAG_LT;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_ras_err        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_redirect_valid <= w_taken;
            r_ras_err        <= w_ret_err;
            if (flags_wr_en) begin
                r_flags <= flags_wr_data;
            end
            if (w_taken) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    assign br_ready       = (r_state == ST_IDLE);
    assign flush          = (r_state == ST_FLUSH);
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flags_q        = r_flags;
    assign ras_empty      = w_ras_empty;
    assign ras_full       = w_ras_full;
    assign ras_err        = r_ras_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed stimulus with a behavioural reference model (flags variable,
// queue-based return stack, flush countdown) compared on every falling edge,
// plus hand-computed literal expectations for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int PC_W         = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int RAS_DEPTH    = 4;

    logic            clk;
    logic            rst;
    logic            flags_wr_en;
    logic [1:0]      flags_wr_data;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_op;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_offset;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
    logic [1:0]      flags_q;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    int n_chk = 0;
    int n_err = 0;

    branch_resolve_unit #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .RAS_DEPTH    (RAS_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flags_wr_en    (flags_wr_en),
        .flags_wr_data  (flags_wr_data),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_op          (br_op),
        .br_pc          (br_pc),
        .br_offset      (br_offset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .flags_q        (flags_q),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .ras_err        (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]      m_flags;
    logic [PC_W-1:0] m_ras[$];
    int              m_left;      // flush cycles still to come, including current
    logic            m_rv;
    logic [PC_W-1:0] m_rpc;
    logic            m_err;

    initial begin
        m_flags = 2'b00; m_left = 0; m_rv = 1'b0; m_rpc = '0; m_err = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_flags = 2'b00;
                m_ras.delete();
                m_left  = 0;
                m_rv    = 1'b0;
                m_rpc   = '0;
                m_err   = 1'b0;
            end else begin
                logic [1:0]      f;
                logic            tk;
                logic            er;
                logic [PC_W-1:0] tgt;
                logic [PC_W-1:0] ra;
                f   = flags_wr_en ? flags_wr_data : m_flags;
                tk  = 1'b0;
                er  = 1'b0;
                tgt = br_pc + br_offset;
                ra  = br_pc + 16'd1;
                if (br_valid && m_left == 0) begin
                    case (br_op)
                        3'd0: tk = 1'b1;
                        3'd1: tk = (f == 2'b01);
                        3'd2: tk = (f == 2'b10);
                        3'd3: tk = (f == 2'b00);
                        3'd4: begin
                            tk = 1'b1;
                            if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
                            m_ras.push_back(ra);
                        end
                        3'd5: begin
                            tk = 1'b1;
                            if (m_ras.size() > 0) tgt = m_ras.pop_back();
                            else begin
                                tgt = '0;
                                er  = 1'b1;
                            end
                        end
                        default: tk = 1'b0;
                    endcase
                end
                if (tk) m_left = FLUSH_CYCLES;
                else if (m_left > 0) m_left--;
                m_rv  = tk;
                m_err = er;
                if (tk) m_rpc = tgt;
                if (flags_wr_en) m_flags = flags_wr_data;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
            if (m_rv) chk("m_redirect_pc", 32'(redirect_pc), 32'(m_rpc));
            chk("m_flush", 32'(flush), 32'(m_left > 0));
            chk("m_br_ready", 32'(br_ready), 32'(m_left == 0));
            chk("m_flags_q", 32'(flags_q), 32'(m_flags));
            chk("m_ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            chk("m_ras_full", 32'(ras_full), 32'(m_ras.size() == RAS_DEPTH));
            chk("m_ras_err", 32'(ras_err), 32'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [PC_W-1:0] pc,
                         input logic [PC_W-1:0] off, input logic fwe, input logic [1:0] fwd);
        br_valid      = v;
        br_op         = op;
        br_pc         = pc;
        br_offset     = off;
        flags_wr_en   = fwe;
        flags_wr_data = fwd;
        step();
        br_valid      = 1'b0;
        br_op         = 3'd0;
        br_pc         = '0;
        br_offset     = '0;
        flags_wr_en   = 1'b0;
        flags_wr_data = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        flags_wr_en = 1'b0; flags_wr_data = 2'b00;
        br_valid = 1'b0; br_op = 3'd0; br_pc = '0; br_offset = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state after idle
        repeat (3) step();
        chk("rst_flags_q", 32'(flags_q), 32'h0);
        chk("rst_br_ready", 32'(br_ready), 32'h1);
        chk("rst_ras_empty", 32'(ras_empty), 32'h1);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("rst_ras_err", 32'(ras_err), 32'h0);

        // 2: BEQ taken after flag write, then BEQ ignored during flush
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 2'b01);
        drive(1'b1, 3'd1, 16'h0010, 16'h0005, 1'b0, 2'b00);
        chk("beq_rv", 32'(redirect_valid), 32'h1);
        chk("beq_rpc", 32'(redirect_pc), 32'h0015);
        chk("beq_flush1", 32'(flush), 32'h1);
        chk("beq_ready1", 32'(br_ready), 32'h0);
        drive(1'b1, 3'd1, 16'h0200, 16'h0001, 1'b0, 2'b00);
        chk("beq_flush2", 32'(flush), 32'h1);
        chk("beq_ready2", 32'(br_ready), 32'h0);
        chk("beq_ignored_rv", 32'(redirect_valid), 32'h0);
        step();
        chk("beq_flush_end", 32'(flush), 32'h0);
        chk("beq_ready_back", 32'(br_ready), 32'h1);
        chk("beq_no_second_rv", 32'(redirect_valid), 32'h0);

        // 3: bypass of same-cycle flag write, then BEQ not taken on GT
        drive(1'b1, 3'd2, 16'h0100, 16'hFFF0, 1'b1, 2'b10);
        chk("bgt_bypass_rv", 32'(redirect_valid), 32'h1);
        chk("bgt_bypass_rpc", 32'(redirect_pc), 32'h00F0);
        chk("bgt_flags_q", 32'(flags_q), 32'h2);
        repeat (2) step();
        drive(1'b1, 3'd1, 16'h0300, 16'h0010, 1'b0, 2'b00);
        chk("beq_nt_rv", 32'(redirect_valid), 32'h0);
        chk("beq_nt_flush", 32'(flush), 32'h0);
        chk("beq_nt_ready", 32'(br_ready), 32'h1);

        // 4: target wraps
        drive(1'b1, 3'd0, 16'hFFFE, 16'h0004, 1'b0, 2'b00);
        chk("wrap_rpc", 32'(redirect_pc), 32'h0002);
        repeat (2) step();

        // 5: RAS overflow and underflow
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 3'd4, 16'(i * 16), 16'h0100, 1'b0, 2'b00);
            chk("call_rpc", 32'(redirect_pc), 32'(i * 16 + 16'h0100));
            chk("call_full", 32'(ras_full), 32'(i >= 4));
            repeat (2) step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'd5, 16'h0700, 16'h0000, 1'b0, 2'b00);
            chk("ret_rpc", 32'(redirect_pc), 32'h51 - 32'(k * 16));
            chk("ret_err_quiet", 32'(ras_err), 32'h0);
            repeat (2) step();
        end
        chk("ret_empty", 32'(ras_empty), 32'h1);
        drive(1'b1, 3'd5, 16'h0700, 16'h0000, 1'b0, 2'b00);
        chk("underflow_rv", 32'(redirect_valid), 32'h1);
        chk("underflow_rpc", 32'(redirect_pc), 32'h0000);
        chk("underflow_err", 32'(ras_err), 32'h1);
        chk("underflow_flush", 32'(flush), 32'h1);
        step();
        chk("underflow_err_pulse", 32'(ras_err), 32'h0);
        step();

        // reserved opcode: no effect
        drive(1'b1, 3'd6, 16'h0040, 16'h0004, 1'b0, 2'b00);
        chk("rsvd_rv", 32'(redirect_valid), 32'h0);
        chk("rsvd_ready", 32'(br_ready), 32'h1);

        // 6: reset during the first flush cycle
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 2'b10);
        drive(1'b1, 3'd4, 16'h0080, 16'h0010, 1'b0, 2'b00);
        repeat (2) step();
        drive(1'b1, 3'd0, 16'h0010, 16'h0010, 1'b0, 2'b00);
        chk("pre_rst_flush", 32'(flush), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flush", 32'(flush), 32'h0);
        chk("async_rst_rv", 32'(redirect_valid), 32'h0);
        chk("async_rst_ready", 32'(br_ready), 32'h1);
        chk("async_rst_ras_empty", 32'(ras_empty), 32'h1);
        chk("async_rst_flags", 32'(flags_q), 32'h0);
        step();
        rst = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
